// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter generator.
package pc_pkg;

    typedef enum logic [1:0] {
        PC_BOOT,
        PC_RUN,
        PC_HALT
    } pc_state_t;

    localparam logic [31:0] PC_RESET_VEC_DEF = 32'h0000_0000;
    localparam logic [31:0] PC_TRAP_VEC_DEF  = 32'h0000_0100;

    // STEP is a power of two, so STEP-1 covers exactly the low log2(STEP) bits.
    function automatic logic [63:0] pc_align_mask(input int unsigned step);
        return 64'(step) - 64'd1;
    endfunction

endpackage

// File: rtl/pc_ctrl_fsm.sv
// BOOT/RUN/HALT sequencer with post-reset boot delay and registered handshake flags.
module pc_ctrl_fsm
    import pc_pkg::*;
#(
    parameter int unsigned BOOT_CYCLES = 1
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      halt_req_i,
    output pc_state_t state_o,
    output logic      pc_valid_o,
    output logic      halted_o
);

    localparam int unsigned BootW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam logic [BootW-1:0] BootLast = BootW'((BOOT_CYCLES == 0) ? 0 : BOOT_CYCLES - 1);

    pc_state_t        state_q;
    logic [BootW-1:0] boot_cnt_q;
    logic             pc_valid_q;
    logic             halted_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= PC_BOOT;
            boot_cnt_q <= '0;
            pc_valid_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            unique case (state_q)
                PC_BOOT: begin
                    // BOOT_CYCLES of 0 and 1 both leave on the first edge with rst low.
                    if (boot_cnt_q >= BootLast) begin
                        state_q    <= PC_RUN;
                        pc_valid_q <= 1'b1;
                    end else begin
                        boot_cnt_q <= boot_cnt_q + BootW'(1);
                    end
                end
                PC_RUN: begin
                    if (halt_req_i) begin
                        state_q    <= PC_HALT;
                        pc_valid_q <= 1'b0;
                        halted_q   <= 1'b1;
                    end
                end
                PC_HALT: begin
                    if (!halt_req_i) begin
                        state_q    <= PC_RUN;
                        pc_valid_q <= 1'b1;
                        halted_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= PC_BOOT;
                    boot_cnt_q <= '0;
                    pc_valid_q <= 1'b0;
                    halted_q   <= 1'b0;
                end
            endcase
        end
    end

    assign state_o    = state_q;
    assign pc_valid_o = pc_valid_q;
    assign halted_o   = halted_q;

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage PC generator: trap/redirect/increment mux, alignment flag and fetch counter.
module pc_gen
    import pc_pkg::*;
#(
    parameter int unsigned        XLEN        = 32,
    parameter logic [XLEN-1:0]    RESET_VEC   = XLEN'(PC_RESET_VEC_DEF),
    parameter logic [XLEN-1:0]    TRAP_VEC    = XLEN'(PC_TRAP_VEC_DEF),
    parameter int unsigned        STEP        = 4,
    parameter int unsigned        BOOT_CYCLES = 1,
    parameter int unsigned        CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             redirect_valid_i,
    input  logic [XLEN-1:0]  redirect_target_i,
    input  logic             trap_valid_i,
    input  logic             halt_req_i,
    input  logic             pc_ready_i,
    output logic [XLEN-1:0]  pc_out_o,
    output logic [XLEN-1:0]  pc_next_seq_o,
    output logic             pc_valid_o,
    output logic             misaligned_o,
    output logic             halted_o,
    output logic [CNT_W-1:0] fetch_count_o
);

    localparam logic [XLEN-1:0] AlignMask = XLEN'(pc_align_mask(STEP));
    localparam logic [XLEN-1:0] StepInc   = XLEN'(STEP);

    pc_state_t        state;
    logic             pc_valid;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mis_q, mis_d;

    pc_ctrl_fsm #(
        .BOOT_CYCLES (BOOT_CYCLES)
    ) u_ctrl (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .halt_req_i (halt_req_i),
        .state_o    (state),
        .pc_valid_o (pc_valid),
        .halted_o   (halted_o)
    );

    // Trap/redirect squash any handshake in the same cycle, even under back-pressure.
    always_comb begin
        pc_d  = pc_q;
        cnt_d = cnt_q;
        mis_d = 1'b0;
        if (state != PC_BOOT) begin
            if (trap_valid_i) begin
                pc_d = TRAP_VEC;
            end else if (redirect_valid_i) begin
                pc_d  = redirect_target_i & ~AlignMask;
                mis_d = |(redirect_target_i & AlignMask);
            end else if (pc_valid && pc_ready_i) begin
                pc_d  = pc_q + StepInc;
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q  <= RESET_VEC;
            cnt_q <= '0;
            mis_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            cnt_q <= cnt_d;
            mis_q <= mis_d;
        end
    end

    assign pc_out_o      = pc_q;
    assign pc_next_seq_o = pc_q + StepInc;
    assign pc_valid_o    = pc_valid;
    assign misaligned_o  = mis_q;
    assign fetch_count_o = cnt_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed, table-driven bench for pc_gen plus an 8-bit instance for wrap-around.
module tb_pc_gen;

    typedef struct {
        logic        rst;
        logic        rv;
        logic [31:0] tgt;
        logic        trap;
        logic        halt;
        logic        rdy;
        logic [31:0] e_pc;
        logic        e_valid;
        logic        e_mis;
        logic        e_halt;
        logic [15:0] e_cnt;
    } vec_t;

    localparam int NVec = 23;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid, trap_valid, halt_req, pc_ready;
    logic [31:0] redirect_target;
    logic [31:0] pc_out, pc_next_seq;
    logic        pc_valid, misaligned, halted;
    logic [15:0] fetch_count;

    logic        rv8, rdy8;
    logic [7:0]  tgt8;
    logic [7:0]  pc8, nseq8;
    logic        valid8, mis8, halted8;
    logic [7:0]  cnt8;

    int checks = 0;
    int errors = 0;
    vec_t vecs [NVec];

    always #5 clk = ~clk;

    pc_gen dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .redirect_valid_i  (redirect_valid),
        .redirect_target_i (redirect_target),
        .trap_valid_i      (trap_valid),
        .halt_req_i        (halt_req),
        .pc_ready_i        (pc_ready),
        .pc_out_o          (pc_out),
        .pc_next_seq_o     (pc_next_seq),
        .pc_valid_o        (pc_valid),
        .misaligned_o      (misaligned),
        .halted_o          (halted),
        .fetch_count_o     (fetch_count)
    );

    pc_gen #(
        .XLEN      (8),
        .RESET_VEC (8'h00),
        .TRAP_VEC  (8'h40),
        .STEP      (4),
        .CNT_W     (8)
    ) dut8 (
        .clk_i             (clk),
        .rst_i             (rst),
        .redirect_valid_i  (rv8),
        .redirect_target_i (tgt8),
        .trap_valid_i      (1'b0),
        .halt_req_i        (1'b0),
        .pc_ready_i        (rdy8),
        .pc_out_o          (pc8),
        .pc_next_seq_o     (nseq8),
        .pc_valid_o        (valid8),
        .misaligned_o      (mis8),
        .halted_o          (halted8),
        .fetch_count_o     (cnt8)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic rv, input logic [31:0] tgt,
                                input logic trap, input logic halt, input logic rdy,
                                input logic [31:0] pc, input logic v, input logic m,
                                input logic h, input logic [15:0] c);
        vec_t t;
        t.rst = r;  t.rv = rv; t.tgt = tgt; t.trap = trap; t.halt = halt; t.rdy = rdy;
        t.e_pc = pc; t.e_valid = v; t.e_mis = m; t.e_halt = h; t.e_cnt = c;
        return t;
    endfunction

    initial begin
        //            rst rv tgt        trap halt rdy  pc          v  m  h  cnt
        vecs[0]  = mk(1, 0, 32'd0,    0, 0, 0, 32'd0,      0, 0, 0, 16'd0);
        vecs[1]  = mk(1, 0, 32'd0,    0, 0, 1, 32'd0,      0, 0, 0, 16'd0);
        vecs[2]  = mk(0, 0, 32'd0,    0, 0, 1, 32'd0,      1, 0, 0, 16'd0);
        vecs[3]  = mk(0, 0, 32'd0,    0, 0, 1, 32'd4,      1, 0, 0, 16'd1);
        vecs[4]  = mk(0, 0, 32'd0,    0, 0, 1, 32'd8,      1, 0, 0, 16'd2);
        vecs[5]  = mk(0, 0, 32'd0,    0, 0, 1, 32'd12,     1, 0, 0, 16'd3);
        vecs[6]  = mk(0, 0, 32'd0,    0, 0, 0, 32'd12,     1, 0, 0, 16'd3);
        vecs[7]  = mk(0, 0, 32'd0,    0, 0, 0, 32'd12,     1, 0, 0, 16'd3);
        vecs[8]  = mk(0, 0, 32'd0,    0, 0, 1, 32'd16,     1, 0, 0, 16'd4);
        vecs[9]  = mk(0, 1, 32'd40,   0, 0, 0, 32'd40,     1, 0, 0, 16'd4);
        vecs[10] = mk(0, 0, 32'd0,    0, 0, 1, 32'd44,     1, 0, 0, 16'd5);
        vecs[11] = mk(0, 1, 32'd42,   0, 0, 0, 32'd40,     1, 1, 0, 16'd5);
        vecs[12] = mk(0, 0, 32'd0,    0, 0, 0, 32'd40,     1, 0, 0, 16'd5);
        vecs[13] = mk(0, 1, 32'd80,   1, 0, 1, 32'h100,    1, 0, 0, 16'd5);
        vecs[14] = mk(0, 0, 32'd0,    0, 0, 1, 32'h104,    1, 0, 0, 16'd6);
        vecs[15] = mk(0, 0, 32'd0,    0, 1, 1, 32'h108,    0, 0, 1, 16'd7);
        vecs[16] = mk(0, 0, 32'd0,    0, 1, 1, 32'h108,    0, 0, 1, 16'd7);
        vecs[17] = mk(0, 1, 32'd200,  0, 1, 0, 32'd200,    0, 0, 1, 16'd7);
        vecs[18] = mk(0, 0, 32'd0,    0, 0, 0, 32'd200,    1, 0, 0, 16'd7);
        vecs[19] = mk(0, 0, 32'd0,    0, 0, 1, 32'd204,    1, 0, 0, 16'd8);
        vecs[20] = mk(1, 1, 32'd300,  0, 0, 1, 32'd0,      0, 0, 0, 16'd0);
        vecs[21] = mk(0, 0, 32'd0,    1, 0, 1, 32'd0,      1, 0, 0, 16'd0);
        vecs[22] = mk(0, 0, 32'd0,    0, 0, 1, 32'd4,      1, 0, 0, 16'd1);

        rst = 1'b1; redirect_valid = 1'b0; redirect_target = '0; trap_valid = 1'b0;
        halt_req = 1'b0; pc_ready = 1'b0; rv8 = 1'b0; tgt8 = '0; rdy8 = 1'b0;

        for (int i = 0; i < NVec; i++) begin
            @(negedge clk);
            rst             = vecs[i].rst;
            redirect_valid  = vecs[i].rv;
            redirect_target = vecs[i].tgt;
            trap_valid      = vecs[i].trap;
            halt_req        = vecs[i].halt;
            pc_ready        = vecs[i].rdy;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d pc_out", i), pc_out, vecs[i].e_pc);
            chk($sformatf("v%0d pc_next_seq", i), pc_next_seq, vecs[i].e_pc + 32'd4);
            chk($sformatf("v%0d pc_valid", i), {31'd0, pc_valid}, {31'd0, vecs[i].e_valid});
            chk($sformatf("v%0d misaligned", i), {31'd0, misaligned}, {31'd0, vecs[i].e_mis});
            chk($sformatf("v%0d halted", i), {31'd0, halted}, {31'd0, vecs[i].e_halt});
            chk($sformatf("v%0d fetch_count", i), {16'd0, fetch_count}, {16'd0, vecs[i].e_cnt});
        end

        // 8-bit wrap: redirect to 252, then one handshake wraps to 0.
        @(negedge clk);
        pc_ready = 1'b0; trap_valid = 1'b0;
        rv8 = 1'b1; tgt8 = 8'd252;
        @(posedge clk);
        #1;
        chk("w8 pc_at_252", {24'd0, pc8}, 32'd252);
        chk("w8 next_seq_252", {24'd0, nseq8}, 32'd0);
        chk("w8 valid", {31'd0, valid8}, 32'd1);
        @(negedge clk);
        rv8 = 1'b0; rdy8 = 1'b1;
        @(posedge clk);
        #1;
        chk("w8 pc_wrapped", {24'd0, pc8}, 32'd0);
        chk("w8 next_seq_wrapped", {24'd0, nseq8}, 32'd4);
        chk("w8 count", {24'd0, cnt8}, 32'd1);
        chk("w8 misaligned", {31'd0, mis8}, 32'd0);
        chk("w8 halted", {31'd0, halted8}, 32'd0);
        @(negedge clk);
        rdy8 = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
